// File: rtl/npc_seq.sv
// npc_seq: architectural PC register with next-PC select, return-address stack and misaligned-target trap redirect
module npc_seq #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            NPC_Write,
  input  logic [4:0]      NPCOp,
  input  logic [XLEN-1:0] Target,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] NPC,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ret_mismatch,
  output logic            misalign
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);
  localparam logic [4:0] OP_BR = 5'b00001, OP_JAL = 5'b00010, OP_JALR = 5'b00100;
  logic [XLEN-1:0] pc_q, pc_d, pc4;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [AW-1:0]   tp_q, tp_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ret_mismatch_q, ret_mismatch_d, misalign_q, misalign_d;
  logic            redirect, bad, upd, ras_en, push, pop;
  always_comb begin
    pc4 = pc_q + XLEN'(4);
    redirect = NPCOp == OP_BR || NPCOp == OP_JAL || NPCOp == OP_JALR;
    bad = redirect && Target[1:0] != 2'b00;
    NPC = (trap || bad) ? trap_vec : redirect ? Target : pc4;
    upd = NPC_Write || trap;
    ras_en = upd && !trap && !bad;
    push = ras_en && is_call && (NPCOp == OP_JAL || NPCOp == OP_JALR);
    pop = ras_en && is_ret && NPCOp == OP_JALR;
    ras_empty = cnt_q == '0;
    ras_top = ras_empty ? '0 : ras_q[tp_q];
    pc_d = upd ? NPC : pc_q;
    ras_d = ras_q;
    tp_d = tp_q;
    cnt_d = cnt_q;
    if (push && pop) begin
      ras_d[tp_q] = pc4;
      cnt_d = ras_empty ? (AW+1)'(1) : cnt_q;
    end else if (push) begin
      tp_d = tp_q + AW'(1);
      ras_d[tp_q + AW'(1)] = pc4;
      cnt_d = cnt_q == FULL ? FULL : cnt_q + (AW+1)'(1);
    end else if (pop && !ras_empty) begin
      tp_d = tp_q - AW'(1);
      cnt_d = cnt_q - (AW+1)'(1);
    end
    ret_mismatch_d = pop && (ras_empty || Target != ras_top);
    misalign_d = bad && upd && !trap;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      tp_q <= '0;
      cnt_q <= '0;
      ras_q <= '{default: '0};
      ret_mismatch_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      tp_q <= tp_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
      ret_mismatch_q <= ret_mismatch_d;
      misalign_q <= misalign_d;
    end
  end
  assign PC = pc_q;
  assign ret_mismatch = ret_mismatch_q;
  assign misalign = misalign_q;
endmodule
